delay_timer_arb: RTL and testbench

DELAY_TIMER_ARB -- requirements
Module: delay_timer_arb

---
 rtl/delay_timer_arb_pkg.sv | 51 +++++
 rtl/delay_timer_arb_tick_prescaler.sv | 37 +++
 rtl/delay_timer_arb.sv | 132 +++++++++++++
 tb/tb_delay_timer_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_arb_pkg.sv
// delay_timer_arb_pkg
//   Shared definitions for the four-channel delay timer arbiter:
//   channel count, channel index width, FSM state encoding and the
//   channel arbitration helpers used by delay_timer_arb.
//   Configuration macro: DELAY_TIMER_ARB_PRIO_EN (see delay_timer_arb.sv).
package delay_timer_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round-robin pick: search last+1, last+2, ... last+NUM_CH (mod NUM_CH).
    // The loop runs from the farthest offset down so the nearest requester
    // after last is the one that sticks. Offset NUM_CH wraps to last itself,
    // which is therefore the lowest-priority candidate.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] pick;
        pick = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + CH_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Fixed priority pick: channel 0 highest, channel NUM_CH-1 lowest.
    function automatic logic [CH_W-1:0] prio_pick(input logic [NUM_CH-1:0] req);
        logic [CH_W-1:0] pick;
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = CH_W'(i);
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/delay_timer_arb_tick_prescaler.sv
// tick_prescaler
//   Divides clk_in by PRESCALE into a one-cycle tick. Implemented as a
//   down-counter that reloads PRESCALE-1 at terminal count (zero). A
//   synchronous clear reloads the counter so the first tick lands exactly
//   PRESCALE cycles after the clear cycle.
//   Ports:
//     clk_in   - system clock
//     rst_n_in - asynchronous active-low reset (counter forced to 0)
//     clr_in   - synchronous clear / restart of the tick period
//     tick_out - high for one cycle every PRESCALE cycles
module tick_prescaler #(
    parameter int PRESCALE = 12
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr_in,
    output logic tick_out
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre_cnt <= '0;
        end else if (clr_in || (pre_cnt == '0)) begin
            pre_cnt <= RELOAD;
        end else begin
            pre_cnt <= pre_cnt - CW'(1);
        end
    end

    assign tick_out = (pre_cnt == '0);

endmodule

// File: rtl/delay_timer_arb.sv
// delay_timer_arb
//   Four-channel delay timer. Requesting channels are arbitrated in IDLE;
//   the winner is acknowledged, its length is latched into a down-counter
//   decremented once per prescaler tick, and a done pulse is returned to
//   that channel when the count expires. The active channel may cancel.
//   Ports:
//     clk_in      - system clock
//     rst_n_in    - asynchronous active-low reset
//     req_in      - per-channel request level, held until ack
//     len_in      - channel n delay in ticks at [n*LEN_W +: LEN_W]
//     cancel_in   - per-channel abort; only the active channel is honoured
//     ack_out     - one-cycle grant pulse
//     done_out    - one-cycle expiry pulse
//     busy_out    - high while a delay is in progress
//     cur_ch_out  - active or last-granted channel
//   Configuration macro:
//     DELAY_TIMER_ARB_PRIO_EN - fixed priority (ch0 highest) instead of
//                               round-robin arbitration.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grants and latches length on entry
//   RUN   | counting ticks down; cancel from active channel aborts
//   DONE  | counter expired; pulse done_out, return to IDLE
module delay_timer_arb
    import delay_timer_arb_pkg::*;
#(
    parameter int PRESCALE = 12,
    parameter int LEN_W    = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_CH-1:0]        req_in,
    input  logic [NUM_CH*LEN_W-1:0]  len_in,
    input  logic [NUM_CH-1:0]        cancel_in,
    output logic [NUM_CH-1:0]        ack_out,
    output logic [NUM_CH-1:0]        done_out,
    output logic                     busy_out,
    output logic [CH_W-1:0]          cur_ch_out
);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [CH_W-1:0]  grant_ch;
    logic [LEN_W-1:0] grant_len;
    logic [LEN_W-1:0] len_arr [NUM_CH];
    logic             grant;
    logic             tick;
    logic             cancel_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_len
        assign len_arr[g] = len_in[g*LEN_W +: LEN_W];
    end

`ifdef DELAY_TIMER_ARB_PRIO_EN
    assign grant_ch = prio_pick(req_in);
`else
    logic [CH_W-1:0] last_grant;
    assign grant_ch = rr_pick(req_in, last_grant);
`endif

    assign grant      = (state == IDLE) && (|req_in);
    assign grant_len  = len_arr[grant_ch];
    assign cancel_hit = cancel_in[cur_ch_out];

    // Clearing in the grant cycle aligns ticks to PRESCALE, 2*PRESCALE, ...
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (grant),
        .tick_out (tick)
    );

`ifndef DELAY_TIMER_ARB_PRIO_EN
    // Reset value NUM_CH-1 makes channel 0 the first round-robin candidate.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            last_grant <= grant_ch;
        end
    end
`endif

    // busy_out reflects the state of the cycle just completed, so it rises
    // the cycle after ack and stays high through the done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            cnt        <= '0;
            ack_out    <= '0;
            done_out   <= '0;
            busy_out   <= 1'b0;
            cur_ch_out <= '0;
        end else begin
            ack_out  <= '0;
            done_out <= '0;
            busy_out <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (grant) begin
                        ack_out    <= ch_onehot(grant_ch);
                        cur_ch_out <= grant_ch;
                        cnt        <= grant_len;
                        state      <= (grant_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Cancel takes precedence over a coincident final tick.
                    if (cancel_hit) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_out <= ch_onehot(cur_ch_out);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arb.sv
// tb_delay_timer_arb
//   Directed, table-driven bench for delay_timer_arb with PRESCALE=12,
//   LEN_W=16. Cycle k is counted from the grant edge (cycle 0 = ack visible);
//   an input "at cycle k" is driven so it is sampled on edge k.
module tb_delay_timer_arb;

    localparam int PS = 12;
    localparam int LW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [3:0]    req_in;
    logic [4*LW-1:0] len_in;
    logic [3:0]    cancel_in;
    logic [3:0]    ack_out;
    logic [3:0]    done_out;
    logic          busy_out;
    logic [1:0]    cur_ch_out;

    int n_tests = 0;
    int n_fail  = 0;

    delay_timer_arb #(
        .PRESCALE (PS),
        .LEN_W    (LW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .req_in     (req_in),
        .len_in     (len_in),
        .cancel_in  (cancel_in),
        .ack_out    (ack_out),
        .done_out   (done_out),
        .busy_out   (busy_out),
        .cur_ch_out (cur_ch_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [63:0] lens;
        int         exp_ch;
        logic [3:0] c_mask;
        int         c_cyc;
        logic [3:0] x_mask;
        int         x_cyc;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Bounded wait for an ack pulse; returns the raw ack vector (0 if none).
    task automatic wait_ack(input int max_cyc, output logic [3:0] ack);
        ack = '0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (ack_out != '0) begin
                ack = ack_out;
                break;
            end
        end
    endtask

    // Bounded wait for done; returns cycles since call (-1 if none) and value.
    task automatic wait_done(input int max_cyc, output int cyc, output logic [3:0] val);
        cyc = -1;
        val = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (done_out != '0) begin
                cyc = i;
                val = done_out;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] ack;
        logic [3:0] done_val;
        int len, exp_end, exp_done, done_cyc, busy_err;
        len_in = v.lens;
        req_in = v.req;
        wait_ack(8, ack);
        req_in = '0;
        chk({v.name, " ack"}, int'(ack), int'(4'b0001 << v.exp_ch));
        chk({v.name, " cur_ch"}, int'(cur_ch_out), v.exp_ch);
        len      = int'(v.lens[v.exp_ch*LW +: LW]);
        exp_end  = (v.c_cyc >= 0) ? v.c_cyc : len * PS + 1;
        exp_done = (v.c_cyc >= 0) ? -1 : exp_end;
        done_cyc = -1;
        done_val = '0;
        busy_err = 0;
        cancel_in = '0;
        for (int c = 1; c <= exp_end + 3; c++) begin
            step();
            cancel_in = ((c + 1 == v.c_cyc) ? v.c_mask : 4'b0000) |
                        ((c + 1 == v.x_cyc) ? v.x_mask : 4'b0000);
            if (done_out != '0 && done_cyc < 0) begin
                done_cyc = c;
                done_val = done_out;
            end
            if (busy_out !== (c <= exp_end)) busy_err++;
        end
        cancel_in = '0;
        chk({v.name, " done_cycle"}, done_cyc, exp_done);
        if (exp_done >= 0)
            chk({v.name, " done_val"}, int'(done_val), int'(4'b0001 << v.exp_ch));
        chk({v.name, " busy_window_errors"}, busy_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] ack;
        logic [3:0] dval;
        int dcyc, seen;
        int rr_exp [5];

        tbl[0] = '{"len3_ch0",  4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 0, 4'b0000, -1, 4'b0000, -1};
        tbl[1] = '{"len0_ch1",  4'b0010, {16'd0, 16'd0, 16'd0, 16'd0}, 1, 4'b0000, -1, 4'b0000, -1};
        tbl[2] = '{"cancel_ch2", 4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 2, 4'b0100, 30, 4'b1000, 10};
`ifdef DELAY_TIMER_ARB_PRIO_EN
        tbl[3] = '{"arb_1010_a", 4'b1010, {16'd2, 16'd0, 16'd1, 16'd0}, 1, 4'b0000, -1, 4'b0000, -1};
`else
        tbl[3] = '{"arb_1010_a", 4'b1010, {16'd2, 16'd0, 16'd1, 16'd0}, 3, 4'b0000, -1, 4'b0000, -1};
`endif
        tbl[4] = '{"arb_1010_b", 4'b1010, {16'd2, 16'd0, 16'd1, 16'd0}, 1, 4'b0000, -1, 4'b0000, -1};
        tbl[5] = '{"cancel_final_tick", 4'b0001, {16'd0, 16'd0, 16'd0, 16'd2}, 0, 4'b0001, 24, 4'b0000, -1};

        rst_n_in  = 1'b0;
        req_in    = '0;
        len_in    = '0;
        cancel_in = '0;
        #1;
        chk("reset ack", int'(ack_out), 0);
        chk("reset done", int'(done_out), 0);
        chk("reset busy", int'(busy_out), 0);
        chk("reset cur_ch", int'(cur_ch_out), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Reset in the middle of a run of length 4 on channel 2.
        len_in = {16'd0, 16'd4, 16'd0, 16'd0};
        req_in = 4'b0100;
        wait_ack(8, ack);
        req_in = '0;
        chk("midreset ack", int'(ack), 4);
        repeat (20) step();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("midreset ack0", int'(ack_out), 0);
        chk("midreset done0", int'(done_out), 0);
        chk("midreset busy0", int'(busy_out), 0);
        chk("midreset cur_ch0", int'(cur_ch_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_done(60, dcyc, dval);
        chk("midreset no_done", dcyc, -1);

        // All four requesting with length 1: grant order after reset.
`ifdef DELAY_TIMER_ARB_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        len_in = {16'd1, 16'd1, 16'd1, 16'd1};
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(8, ack);
            chk($sformatf("arb1111 grant%0d", k), int'(ack), int'(4'b0001 << rr_exp[k]));
            wait_done(20, dcyc, dval);
            if (k == 4) req_in = '0;
            chk($sformatf("arb1111 done_cycle%0d", k), dcyc, PS + 1);
        end
        repeat (2) step();

        // Length changed after grant has no effect.
        len_in = {16'd0, 16'd0, 16'd2, 16'd0};
        req_in = 4'b0010;
        wait_ack(8, ack);
        req_in = '0;
        chk("lenchg ack", int'(ack), 2);
        repeat (5) step();
        len_in = {16'd0, 16'd0, 16'd9, 16'd0};
        wait_done(40, dcyc, dval);
        chk("lenchg done_cycle", dcyc + 5, 2 * PS + 1);
        chk("lenchg done_val", int'(dval), 2);

        // A request raised and dropped during RUN is never granted.
        len_in = {16'd0, 16'd0, 16'd0, 16'd3};
        req_in = 4'b0001;
        wait_ack(8, ack);
        req_in = '0;
        chk("drop ack", int'(ack), 1);
        repeat (10) step();
        req_in = 4'b1000;
        repeat (10) step();
        req_in = '0;
        wait_done(30, dcyc, dval);
        chk("drop done_cycle", dcyc + 20, 3 * PS + 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_out != '0) seen++;
        end
        chk("drop no_ack", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
